tensor_link_host: RTL and testbench
===================================

# tensor_link_host

Host-side end of the tensor core's bit-serial link. It buffers a full job of A/B operand words from a parallel valid/ready source and serializes them LSB-first onto the core's two serial inputs, one bit per clock. It then deserializes the core's 32-bit result stream into parallel words. It also owns the core's active-low reset, so each job starts from a clean core.

## Interface
- WORDS, 16: operand/result words per job
- IN_W, 16: operand word width
- OUT_W, 32: result word width
- RX_DELAY, 2: cycles from the end of the last TX gap cycle to result word 0, bit 0 on serial_in
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  high while buffering operands (FILL)
- in_a  in  IN_W  A word, index = acceptance order
- in_b  in  IN_W  B word, same index
- serial_a  out  1  to core serial_in_a
- serial_b  out  1  to core serial_in_b
- serial_in  in  1  from core serial_out
- core_rst_n  out  1  core reset, low except during TX/RX_WAIT/RX
- out_valid  out  1  one-cycle strobe per result word; no backpressure
- out_data  out  OUT_W  result word
- out_index  out  $clog2(WORDS)  result word index
- busy  out  1  high from first accepted word through the done cycle
- done  out  1  one-cycle pulse after the last result word

## Operation
- FSM states: FILL → TX → RX_WAIT → RX → DONE → FILL.
- FILL:
  - in_ready=1; each in_valid&&in_ready writes the pair into buffer slot wcnt, then wcnt++.
  - On the WORDS-th acceptance, go to TX; in_ready drops the next cycle.
- TX:
  - core_rst_n=1.
  - Each word takes 17 cycles: 16 data cycles (bit b of word w), then 1 gap cycle with serial_a/b=0.
  - No stalls are possible, because all data is already buffered.
- RX_WAIT: counts RX_DELAY cycles with serial_a/b=0.
- RX:
  - Each result word takes 33 cycles: 32 data cycles, each shifting serial_in into bit position j (LSB first), then 1 gap cycle.
  - In the gap cycle: out_valid=1, out_data=assembled word, out_index=k.
- DONE:
  - done=1, core_rst_n=0, wcnt=0.
  - Next cycle the FSM is in FILL.
- in_valid outside FILL is ignored (in_ready=0). serial_in outside RX is ignored.
- Counters: bit counter 0..32, word counter 0..WORDS-1. Both wrap to 0 at every phase boundary.

## Timing
- Reset values:
  - State FILL, wcnt=0.
  - in_ready=1 from the first cycle after reset.
  - serial_a=serial_b=0, core_rst_n=0.
  - out_valid=0, out_data=0, out_index=0, busy=0, done=0.
- All outputs are registered.
- T0 = first TX cycle, which is the cycle after the last acceptance. At T0, core_rst_n first reads 1.
- serial_a/serial_b carry bit b of word w at cycle T0+17w+b.
- The gap cycle for word w is at T0+17w+16. The last TX cycle is T0+17·WORDS−1 (T0+271 at defaults).
- Result word k, bit j is sampled at R0+33k+j, where R0 = T0+17·WORDS+RX_DELAY.
- out_valid for word k is at R0+33k+32. done is at R0+33·WORDS, i.e. T0+274+528 at defaults.
- rst mid-job (any state): on the next cycle the block is in FILL, the buffer contents are discarded, and core_rst_n=0. There is no partial output.
- The last FILL acceptance and the TX entry never coincide with a new acceptance: in_ready is low from T0.

## Structure
- Package tensor_link_pkg holds:
  - state enum (FILL, TX, RX_WAIT, RX, DONE);
  - localparams TX_SLOT=IN_W+1 and RX_SLOT=OUT_W+1;
  - counter width functions.
- Sub-module tensor_link_deser: an OUT_W-bit LSB-first shift/capture register.
  - Inputs: clk, rst, en, bit_idx, serial_in.
  - Output: word.
  - Instantiated once for RX.
- The operand buffer is two WORDS×IN_W register arrays in the top module.

## Test plan
- Fill with A[i]=16'h0001<<i, B[i]=16'hFFFF−i. Check:
  - serial_a is 1 only at cycle T0+17i+i;
  - serial_b bits match B LSB-first;
  - the gap cycles are 0.
- Drive serial_in as a bit-accurate core model that returns C[k]=32'hA5A5_0000+k with RX_DELAY=2. Check:
  - out_valid occurs 16 times, 33 cycles apart;
  - out_data/out_index are correct;
  - done occurs one cycle after the last word.
- Fill with in_valid toggling every other cycle (gaps). Check:
  - exactly 16 acceptances;
  - TX is cycle-identical to the gapless case, relative to T0.
- Assert rst at T0+100 (mid-TX). Check:
  - next cycle: FILL, core_rst_n=0, serial_a/b=0, busy=0;
  - a following full job completes correctly.
- Run two back-to-back jobs, with in_valid held high through the whole first job. Check:
  - no acceptance outside FILL;
  - job 2 T0 equals the job 1 done cycle + 17 (fill time);
  - job 2 results are independent of job 1.
- Check the reset-value sweep: all outputs match their reset values one cycle after rst.

Source files
------------

// File: rtl/tensor_link_pkg.sv
// -----------------------------------------------------------------------------
// tensor_link_pkg
// Shared definitions for the host side of the tensor core bit-serial link:
// the link FSM state encoding, default word geometry, slot lengths (data bits
// plus one gap cycle) and a counter-width helper.
// -----------------------------------------------------------------------------
package tensor_link_pkg;

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_TX      = 3'd1,
        S_RX_WAIT = 3'd2,
        S_RX      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int WORDS_DEF = 16;
    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 32;

    // A serial slot is the word's data bits followed by one idle gap cycle.
    function automatic int slot_len(input int word_w);
        return word_w + 1;
    endfunction

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int TX_SLOT = slot_len(IN_W_DEF);
    localparam int RX_SLOT = slot_len(OUT_W_DEF);

endpackage

// File: rtl/tensor_link_deser.sv
// -----------------------------------------------------------------------------
// tensor_link_deser
// LSB-first capture register for the result stream. Each enabled cycle writes
// serial_in into bit position bit_idx, so a word is complete after OUT_W
// enabled cycles. Bits are simply overwritten by the next word.
//   clk, rst   : clock, synchronous active-high reset (blocks capture)
//   en         : capture this cycle
//   bit_idx    : destination bit position
//   serial_in  : serial result bit from the core
//   word       : captured bits
// -----------------------------------------------------------------------------
module tensor_link_deser
    import tensor_link_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [$clog2(OUT_W)-1:0] bit_idx,
    input  logic                     serial_in,
    output logic [OUT_W-1:0]         word
);

    always_ff @(posedge clk) begin
        if (!rst && en) begin
            word[bit_idx] <= serial_in;
        end
    end

endmodule

// File: rtl/tensor_link_host.sv
// -----------------------------------------------------------------------------
// tensor_link_host
// Host end of the tensor core bit-serial link. Buffers a job of WORDS operand
// pairs, streams them LSB-first to the core (one gap cycle per word), waits
// RX_DELAY cycles, then collects WORDS OUT_W-bit results from serial_in.
// The core is held in reset whenever no job is on the wire.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake, in_ready only during FILL
//   in_a, in_b         : operand pair, slot = acceptance order
//   serial_a/serial_b  : serial operand bits to the core
//   serial_in          : serial result bits from the core
//   core_rst_n         : core reset, released during TX/RX_WAIT/RX
//   out_valid/out_data/out_index : one strobe per result word
//   busy               : job in progress (first acceptance through done)
//   done               : one-cycle end-of-job pulse
// All outputs are registered: they are computed from the next-state values.
// -----------------------------------------------------------------------------
module tensor_link_host
    import tensor_link_pkg::*;
#(
    parameter int WORDS    = WORDS_DEF,
    parameter int IN_W     = IN_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int RX_DELAY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_a,
    input  logic [IN_W-1:0]          in_b,
    output logic                     serial_a,
    output logic                     serial_b,
    input  logic                     serial_in,
    output logic                     core_rst_n,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(WORDS)-1:0] out_index,
    output logic                     busy,
    output logic                     done
);

    // Package slot lengths, shifted if the width parameters are overridden.
    localparam int TX_LEN  = TX_SLOT + (IN_W - IN_W_DEF);
    localparam int RX_LEN  = RX_SLOT + (OUT_W - OUT_W_DEF);
    localparam int MAX_A   = (TX_LEN > RX_LEN) ? TX_LEN : RX_LEN;
    localparam int BIT_MAX = ((MAX_A > RX_DELAY) ? MAX_A : RX_DELAY) - 1;
    localparam int BIT_W   = cnt_w(BIT_MAX);
    localparam int IDX_W   = $clog2(WORDS);
    localparam int IN_BW   = $clog2(IN_W);
    localparam int OUT_BW  = $clog2(OUT_W);

    state_t           state, state_n;
    logic [BIT_W-1:0] bcnt, bcnt_n;
    logic [IDX_W-1:0] wcnt, wcnt_n;
    logic             accept;

    logic [IN_W-1:0]  buf_a [WORDS];
    logic [IN_W-1:0]  buf_b [WORDS];

    logic             tx_on, tx_bit_a, tx_bit_b;
    logic             rx_en, rx_last;
    logic [OUT_W-1:0] deser_word, rx_word;

    // Shared counters: wcnt is the fill slot in FILL and the word index in
    // TX/RX; bcnt is the bit/gap position, and also the RX_WAIT delay count.
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        wcnt_n  = wcnt;
        accept  = 1'b0;
        case (state)
            S_FILL: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (wcnt == IDX_W'(WORDS - 1)) begin
                        state_n = S_TX;
                        wcnt_n  = '0;
                        bcnt_n  = '0;
                    end else begin
                        wcnt_n = wcnt + IDX_W'(1);
                    end
                end
            end
            S_TX: begin
                if (bcnt == BIT_W'(TX_LEN - 1)) begin
                    bcnt_n = '0;
                    if (wcnt == IDX_W'(WORDS - 1)) begin
                        wcnt_n  = '0;
                        state_n = S_RX_WAIT;
                    end else begin
                        wcnt_n = wcnt + IDX_W'(1);
                    end
                end else begin
                    bcnt_n = bcnt + BIT_W'(1);
                end
            end
            S_RX_WAIT: begin
                if (bcnt == BIT_W'(RX_DELAY - 1)) begin
                    bcnt_n  = '0;
                    state_n = S_RX;
                end else begin
                    bcnt_n = bcnt + BIT_W'(1);
                end
            end
            S_RX: begin
                if (bcnt == BIT_W'(RX_LEN - 1)) begin
                    bcnt_n = '0;
                    if (wcnt == IDX_W'(WORDS - 1)) begin
                        wcnt_n  = '0;
                        state_n = S_DONE;
                    end else begin
                        wcnt_n = wcnt + IDX_W'(1);
                    end
                end else begin
                    bcnt_n = bcnt + BIT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_FILL;
                wcnt_n  = '0;
                bcnt_n  = '0;
            end
            default: begin
                state_n = S_FILL;
                wcnt_n  = '0;
                bcnt_n  = '0;
            end
        endcase
    end

    // Serial operand bits for the coming cycle; the gap position reads as 0.
    always_comb begin
        tx_on    = (state_n == S_TX) && (bcnt_n < BIT_W'(IN_W));
        tx_bit_a = tx_on & buf_a[wcnt_n][bcnt_n[IN_BW-1:0]];
        tx_bit_b = tx_on & buf_b[wcnt_n][bcnt_n[IN_BW-1:0]];
    end

    // The final data bit arrives on the same edge that loads out_data, so it
    // is merged straight from serial_in rather than from the deserializer.
    always_comb begin
        rx_en   = (state == S_RX) && (bcnt < BIT_W'(OUT_W));
        rx_last = (state == S_RX) && (bcnt == BIT_W'(OUT_W - 1));
        rx_word = deser_word;
        rx_word[OUT_W-1] = serial_in;
    end

    tensor_link_deser #(
        .OUT_W(OUT_W)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .en       (rx_en),
        .bit_idx  (bcnt[OUT_BW-1:0]),
        .serial_in(serial_in),
        .word     (deser_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            bcnt       <= '0;
            wcnt       <= '0;
            in_ready   <= 1'b1;
            serial_a   <= 1'b0;
            serial_b   <= 1'b0;
            core_rst_n <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            bcnt       <= bcnt_n;
            wcnt       <= wcnt_n;
            in_ready   <= (state_n == S_FILL);
            serial_a   <= tx_bit_a;
            serial_b   <= tx_bit_b;
            core_rst_n <= (state_n == S_TX) || (state_n == S_RX_WAIT) ||
                          (state_n == S_RX);
            out_valid  <= rx_last;
            if (rx_last) begin
                out_data  <= rx_word;
                out_index <= wcnt;
            end
            busy       <= (state_n != S_FILL) || (wcnt_n != '0);
            done       <= (state_n == S_DONE);
        end
    end

    // Operand storage carries no reset; a restarted fill overwrites it.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_a[wcnt] <= in_a;
            buf_b[wcnt] <= in_b;
        end
    end

endmodule

// File: tb/tb_tensor_link_host.sv
// -----------------------------------------------------------------------------
// tb_tensor_link_host
// Self-checking bench for tensor_link_host. A job-timeline model predicts
// every output each cycle from the accepted operands and the results the core
// model returns; a bit-level core model drives serial_in from its own view of
// core_rst_n. Literal expectations pin the model on the directed jobs.
// -----------------------------------------------------------------------------
module tb_tensor_link_host;

    localparam int WORDS    = 16;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 32;
    localparam int RX_DELAY = 2;
    localparam int TXS      = IN_W + 1;
    localparam int RXS      = OUT_W + 1;
    localparam int R0_REL   = WORDS * TXS + RX_DELAY;
    localparam int DONE_REL = R0_REL + WORDS * RXS;
    localparam int NJOBS    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [IN_W-1:0]   in_a = '0;
    logic [IN_W-1:0]   in_b = '0;
    logic              serial_in = 1'b0;
    logic              in_ready, serial_a, serial_b, core_rst_n;
    logic              out_valid, busy, done;
    logic [OUT_W-1:0]  out_data;
    logic [3:0]        out_index;

    tensor_link_host #(
        .WORDS(WORDS), .IN_W(IN_W), .OUT_W(OUT_W), .RX_DELAY(RX_DELAY)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .serial_a(serial_a), .serial_b(serial_b),
        .serial_in(serial_in), .core_rst_n(core_rst_n),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Results the core hands back, one row per job start.
    logic [OUT_W-1:0] res_tab [NJOBS][WORDS];

    // Model state
    bit              model_on = 1'b0;
    bit              in_job = 1'b0;
    bit              zero_flag = 1'b0;
    int              fill_cnt = 0;
    int              t0 = 0;
    int              job_idx = -1;
    logic [IN_W-1:0] a_m [WORDS];
    logic [IN_W-1:0] b_m [WORDS];

    // Observations of the DUT used by the literal checks
    int               acc_obs = 0;
    int               t0_obs = 0;
    int               done_obs = 0;
    int               ones_a = 0;
    int               ov_cnt = 0;
    int               ov_last = 0;
    logic [OUT_W-1:0] first_word = '0;
    logic             crn_prev = 1'b0;

    initial begin : model_proc
        int rel, w, b, k, j;
        logic e_rdy, e_crn, e_sa, e_sb, e_ov, e_done, e_busy;
        forever begin
            @(negedge clk);
            if (model_on) begin
                e_rdy = 1'b1; e_crn = 1'b0; e_sa = 1'b0; e_sb = 1'b0;
                e_ov = 1'b0; e_done = 1'b0; e_busy = (fill_cnt != 0); k = 0;
                if (in_job) begin
                    rel = cyc - t0;
                    e_rdy = 1'b0; e_busy = 1'b1; e_crn = 1'b1;
                    if (rel < WORDS * TXS) begin
                        w = rel / TXS;
                        b = rel % TXS;
                        if (b < IN_W) begin
                            e_sa = a_m[w][b];
                            e_sb = b_m[w][b];
                        end
                    end else if (rel >= R0_REL && rel < DONE_REL) begin
                        k = (rel - R0_REL) / RXS;
                        j = (rel - R0_REL) % RXS;
                        e_ov = (j == OUT_W);
                    end else if (rel == DONE_REL) begin
                        e_crn = 1'b0;
                        e_done = 1'b1;
                    end
                end
                check("in_ready",   64'(in_ready),   64'(e_rdy));
                check("core_rst_n", 64'(core_rst_n), 64'(e_crn));
                check("serial_a",   64'(serial_a),   64'(e_sa));
                check("serial_b",   64'(serial_b),   64'(e_sb));
                check("out_valid",  64'(out_valid),  64'(e_ov));
                check("done",       64'(done),       64'(e_done));
                check("busy",       64'(busy),       64'(e_busy));
                if (e_ov) begin
                    check("out_data",  64'(out_data),  64'(res_tab[job_idx][k]));
                    check("out_index", 64'(out_index), 64'(k));
                    zero_flag = 1'b0;
                end else if (zero_flag) begin
                    check("out_data_rst",  64'(out_data),  64'd0);
                    check("out_index_rst", 64'(out_index), 64'd0);
                end

                if (in_valid && in_ready) acc_obs++;
                if (core_rst_n === 1'b1 && crn_prev !== 1'b1) begin
                    t0_obs = cyc; ones_a = 0; ov_cnt = 0;
                end
                crn_prev = core_rst_n;
                if (serial_a === 1'b1) ones_a++;
                if (out_valid === 1'b1) begin
                    if (ov_cnt > 0) check("ov_spacing", 64'(cyc - ov_last), 64'd33);
                    ov_cnt++;
                    ov_last = cyc;
                    if (ov_cnt == 1) first_word = out_data;
                end
                if (done === 1'b1) done_obs = cyc;
            end

            if (rst) begin
                model_on = 1'b1; in_job = 1'b0; fill_cnt = 0; zero_flag = 1'b1;
            end else if (model_on) begin
                if (!in_job) begin
                    if (in_valid) begin
                        a_m[fill_cnt] = in_a;
                        b_m[fill_cnt] = in_b;
                        fill_cnt++;
                        if (fill_cnt == WORDS) begin
                            in_job = 1'b1; fill_cnt = 0; t0 = cyc + 1; job_idx++;
                        end
                    end
                end else if (cyc - t0 == DONE_REL) begin
                    in_job = 1'b0;
                end
            end
        end
    end

    // Core model: counts cycles from its reset release, returns res_tab rows
    // LSB-first, and emits noise on serial_in whenever it is not sending.
    initial begin : core_proc
        int   rel_c, job_c, q;
        logic prev;
        rel_c = 0; job_c = -1; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (core_rst_n === 1'b1) begin
                if (!prev) begin
                    rel_c = 0;
                    job_c++;
                end else begin
                    rel_c++;
                end
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
            q = rel_c - R0_REL;
            if (prev && rel_c >= R0_REL && rel_c < DONE_REL && (q % RXS) < OUT_W)
                serial_in = res_tab[job_c][q / RXS][q % RXS];
            else
                serial_in = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pat 0: A[i]=1<<i, B[i]=FFFF-i; pat 1: random. gapped toggles in_valid.
    task automatic fill(input bit gapped, input bit pat);
        int i, guard;
        bit tog;
        i = 0; guard = 0; tog = 1'b1;
        while (i < WORDS && guard < 200) begin
            in_valid = gapped ? tog : 1'b1;
            tog = !tog;
            in_a = pat ? 16'($urandom) : 16'(1 << i);
            in_b = pat ? 16'($urandom) : 16'(16'hFFFF - i);
            if (in_valid && in_ready) i++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        check("fill_complete", 64'(i), 64'(WORDS));
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 1000) begin
            step();
            g++;
        end
        check(name, 64'(done), 64'd1);
        step();
    endtask

    initial begin : stim
        int n_done, done4, g;
        for (int jb = 0; jb < NJOBS; jb++)
            for (int k = 0; k < WORDS; k++)
                res_tab[jb][k] = (jb == 0) ? 32'hA5A5_0000 + 32'(k) : 32'($urandom);

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        check("rst_serial_a",   64'(serial_a),   64'd0);
        check("rst_serial_b",   64'(serial_b),   64'd0);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_out_index",  64'(out_index),  64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        repeat (2) step();

        // Job 0: directed pattern, gapless fill
        fill(1'b0, 1'b0);
        wait_done("job0_done");
        check("job0_serial_a_ones", 64'(ones_a), 64'd16);
        check("job0_out_count",     64'(ov_cnt), 64'd16);
        check("job0_first_word",    64'(first_word), 64'hA5A5_0000);
        check("job0_done_after_last", 64'(done_obs - ov_last), 64'd1);
        check("job0_done_time",     64'(done_obs - t0_obs), 64'd802);

        // Job 1: same operands, in_valid toggling during fill
        repeat (3) step();
        acc_obs = 0;
        fill(1'b1, 1'b0);
        check("job1_acceptances", 64'(acc_obs), 64'd16);
        wait_done("job1_done");
        check("job1_serial_a_ones", 64'(ones_a), 64'd16);
        check("job1_done_time",     64'(done_obs - t0_obs), 64'd802);

        // Job 2: random operands, reset at T0+100
        repeat (2) step();
        fill(1'b0, 1'b1);
        g = 0;
        while (core_rst_n !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        check("job2_started", 64'(core_rst_n), 64'd1);
        repeat (100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready",   64'(in_ready),   64'd1);
        check("abort_core_rst_n", 64'(core_rst_n), 64'd0);
        check("abort_serial_a",   64'(serial_a),   64'd0);
        check("abort_serial_b",   64'(serial_b),   64'd0);
        check("abort_busy",       64'(busy),       64'd0);
        repeat (5) step();

        // Job 3: full random job after the abort
        fill(1'b0, 1'b1);
        wait_done("job3_done");
        check("job3_out_count", 64'(ov_cnt), 64'd16);

        // Jobs 4 and 5: in_valid held high throughout, back to back
        n_done = 0; done4 = 0; g = 0;
        in_valid = 1'b1;
        while (n_done < 2 && g < 2500) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            step();
            g++;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) done4 = cyc;
            end
        end
        in_valid = 1'b0;
        check("b2b_done_count", 64'(n_done), 64'd2);
        step();
        check("b2b_t0_gap",     64'(t0_obs - done4), 64'd17);
        check("job5_out_count", 64'(ov_cnt), 64'd16);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
